ram_lsu: RTL and testbench

Load/store unit between the CPU data-memory port and the word-only data RAM peripheral. It accepts one byte-addressed load or store per handshake and converts it to word accesses on the RAM data bus. It performs sub-word lane extraction with sign or zero extension, and read-modify-write for byte and halfword stores. Misaligned, illegal-size and out-of-range requests are rejected with an error response and never reach the bus.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/ram_lsu_if.sv | 27 ++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/ram_lsu.sv | 160 ++++++++++++++++
 tb/tb_ram_lsu.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RAM load/store unit and the word-only data RAM.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  // Out of RAM range, so the RAM stays inactive while the bus is parked here.
  localparam logic [31:0] BUS_IDLE_ADDR = 32'hFFFF_FFFF;

  localparam int unsigned RAM_DEPTH = 100;

endpackage

// File: rtl/ram_lsu_if.sv
// CPU request/response channel plus RAM word bus, as seen by the load/store unit.
interface ram_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] bus_addr;
  logic        bus_w_r;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, bus_addr, bus_w_r, bus_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, bus_addr, bus_w_r, bus_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;

  always_comb begin
    byte_sh  = {lane_i, 3'b000};
    half_sh  = {lane_i[1], 4'b0000};
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase

    load_o  = '0;
    merge_o = word_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o  = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merge_o = (word_i & ~(32'h0000_00FF << byte_sh)) | ({24'h0, wdata_i[7:0]} << byte_sh);
      end
      SIZE_HALF: begin
        load_o  = {{16{signed_i & half_sel[15]}}, half_sel};
        merge_o = (word_i & ~(32'h0000_FFFF << half_sh)) | ({16'h0, wdata_i[15:0]} << half_sh);
      end
      SIZE_WORD: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_lsu.sv
// Load/store unit: byte-addressed CPU requests to word accesses on the data RAM bus,
// with sub-word extraction, read-modify-write stores and error rejection.
module ram_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned RAM_WORDS = RAM_DEPTH
) (
  input logic      clk,
  input logic      rst,
  ram_lsu_if.slave io
);

  localparam logic [29:0] WORDS_C = 30'(RAM_WORDS);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        bus_w_r_q, bus_w_r_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic [29:0] req_widx;
  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign req_widx = io.req_addr[31:2];

  always_comb begin
    req_err = 1'b0;
    if (io.req_size == SIZE_ILL)                               req_err = 1'b1;
    if (io.req_size == SIZE_HALF && io.req_addr[0])            req_err = 1'b1;
    if (io.req_size == SIZE_WORD && io.req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_widx >= WORDS_C)                                   req_err = 1'b1;
  end

  // Fed straight from bus_rdata so the RD-ending edge captures the lane or merged word.
  lsu_lane_align u_align (
    .word_i   (io.bus_rdata),
    .lane_i   (lane_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .merge_o  (merge_val)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    lane_d      = lane_q;
    signed_d    = signed_q;
    wdata_d     = wdata_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    bus_addr_d  = BUS_IDLE_ADDR;
    bus_w_r_d   = 1'b0;
    bus_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (io.req_valid && req_ready_q) begin
          we_d        = io.req_we;
          size_d      = io.req_size;
          lane_d      = io.req_addr[1:0];
          signed_d    = io.req_signed;
          wdata_d     = io.req_wdata;
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (io.req_we && io.req_size == SIZE_WORD) begin
            state_d     = S_WR;
            bus_addr_d  = {2'b00, req_widx};
            bus_w_r_d   = 1'b1;
            bus_wdata_d = io.req_wdata;
          end else begin
            state_d    = S_RD;
            bus_addr_d = {2'b00, req_widx};
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d     = S_WR;
          bus_addr_d  = bus_addr_q;
          bus_w_r_d   = 1'b1;
          bus_wdata_d = merge_val;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_val;
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_addr_q  <= BUS_IDLE_ADDR;
      bus_w_r_q   <= 1'b0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      signed_q    <= signed_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_w_r_q   <= bus_w_r_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign io.req_ready = req_ready_q;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_err   = rsp_err_q;
  assign io.rsp_rdata = rsp_rdata_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_w_r   = bus_w_r_q;
  assign io.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: negedge-sampled RAM model plus a byte-array reference model.
module tb_ram_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  ram_lsu_if io();

  ram_lsu #(.RAM_WORDS(100)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem        [100];
  logic [31:0] seed_words [100];
  logic        preload = 1'b0;
  logic [7:0]  rb         [400];
  int          rsp_seen   = 0;
  int          wr_seen    = 0;
  int          bus_active = 0;

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 100; i++) mem[i] <= seed_words[i];
    end else if (io.bus_addr < 32'd100) begin
      if (io.bus_w_r) mem[io.bus_addr[6:0]] <= io.bus_wdata;
      else            io.bus_rdata <= mem[io.bus_addr[6:0]];
    end
    if (io.rsp_valid) rsp_seen++;
    if (io.bus_w_r) wr_seen++;
    if (io.bus_addr != 32'hFFFF_FFFF || io.bus_w_r) bus_active++;
  end

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  // Byte-addressed memory view: sizes are 1/2/4 bytes, alignment is addr % size.
  function automatic void ref_do(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic e, output logic [31:0] rd, output int lat);
    int unsigned     n;
    longint unsigned v;
    logic [31:0]     sh;
    n  = 1 << size;
    e  = (size == 2'd3) || (addr % n != 0) || (addr / 4 >= 100);
    rd = '0;
    if (e) begin
      lat = 1;
      return;
    end
    if (we) begin
      for (int unsigned i = 0; i < n; i++) begin
        sh = wdata >> (8 * i);
        rb[addr + i] = sh[7:0];
      end
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = 0;
      for (int unsigned i = 0; i < n; i++) v = v | (longint'(rb[addr + i]) << (8 * i));
      if (sgn && n < 4 && (((v >> (8 * n - 1)) & 1) == 1)) v = v | (64'hFFFF_FFFF << (8 * n));
      rd  = v[31:0];
      lat = 2;
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] rdata,
                        output logic [31:0] first_addr, output logic first_wr);
    int n;
    n = 0;
    while (!io.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    io.req_we     = we;
    io.req_size   = size;
    io.req_signed = sgn;
    io.req_addr   = addr;
    io.req_wdata  = wdata;
    io.req_valid  = 1'b1;
    @(posedge clk); #1;
    io.req_valid = 1'b0;
    first_addr   = io.bus_addr;
    first_wr     = io.bus_w_r;
    lat = 1;
    while (!io.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!io.rsp_valid) lat = -1;
    err   = io.rsp_err;
    rdata = io.rsp_rdata;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 100; i++) begin
      seed_words[i] = $urandom;
      {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]} = seed_words[i];
    end
    rst = 1'b1;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    checks++; if (io.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", io.req_ready); end
    checks++; if (io.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", io.rsp_valid); end
    checks++; if (io.rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got=%b exp=0", io.rsp_err); end
    checks++; if (io.rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got=%h exp=0", io.rsp_rdata); end
    checks++; if (io.bus_addr !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_bus_addr got=%h exp=ffffffff", io.bus_addr); end
    checks++; if (io.bus_w_r !== 1'b0) begin fails++; $display("FAIL reset_bus_w_r got=%b exp=0", io.bus_w_r); end
    checks++; if (io.bus_wdata !== 32'h0) begin fails++; $display("FAIL reset_bus_wdata got=%h exp=0", io.bus_wdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat, ml;
    logic err, me;
    logic [31:0] rd, fa, mr;
    logic fw;
    ref_do(1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, me, mr, ml);
    do_req(1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, lat, err, rd, fa, fw);
    checks++; if (fa !== 32'd4 || fw !== 1'b1) begin fails++; $display("FAIL wstore_bus got addr=%h w_r=%b exp addr=4 w_r=1", fa, fw); end
    checks++; if (lat !== 2 || err !== 1'b0) begin fails++; $display("FAIL wstore_rsp got lat=%0d err=%b exp lat=2 err=0", lat, err); end
    do_req(0, SIZE_WORD, 0, 32'h10, 32'h0, lat, err, rd, fa, fw);
    checks++; if (rd !== 32'hDEADBEEF || lat !== 2 || err !== 1'b0) begin fails++; $display("FAIL wload got rd=%h lat=%0d err=%b exp rd=deadbeef lat=2 err=0", rd, lat, err); end
    ref_do(1, SIZE_BYTE, 0, 32'h11, 32'h55, me, mr, ml);
    do_req(1, SIZE_BYTE, 0, 32'h11, 32'h55, lat, err, rd, fa, fw);
    checks++; if (lat !== 3 || fw !== 1'b0 || fa !== 32'd4) begin fails++; $display("FAIL bstore_timing got lat=%0d first_w_r=%b addr=%h exp lat=3 w_r=0 addr=4", lat, fw, fa); end
    checks++; if (mem[4] !== 32'hDEAD55EF) begin fails++; $display("FAIL bstore_merge got=%h exp=dead55ef", mem[4]); end
    do_req(0, SIZE_BYTE, 1, 32'h13, 32'h0, lat, err, rd, fa, fw);
    checks++; if (rd !== 32'hFFFFFFDE || lat !== 2) begin fails++; $display("FAIL bload_signed got=%h lat=%0d exp=ffffffde lat=2", rd, lat); end
    do_req(0, SIZE_BYTE, 0, 32'h13, 32'h0, lat, err, rd, fa, fw);
    checks++; if (rd !== 32'h000000DE) begin fails++; $display("FAIL bload_unsigned got=%h exp=000000de", rd); end
    do_req(0, SIZE_HALF, 1, 32'h12, 32'h0, lat, err, rd, fa, fw);
    checks++; if (rd !== 32'hFFFFDEAD) begin fails++; $display("FAIL hload_signed got=%h exp=ffffdead", rd); end
  endtask

  task automatic test_errors();
    logic        we_t   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  size_t [4] = '{SIZE_HALF, SIZE_WORD, SIZE_ILL, SIZE_WORD};
    logic [31:0] addr_t [4] = '{32'h01, 32'h02, 32'h20, 32'h190};
    int lat, ml, act0;
    logic err, me;
    logic [31:0] rd, fa, mr;
    logic fw;
    @(posedge clk); #1;
    act0 = bus_active;
    for (int i = 0; i < 4; i++) begin
      ref_do(we_t[i], size_t[i], 1'b1, addr_t[i], 32'hA5A5A5A5, me, mr, ml);
      do_req(we_t[i], size_t[i], 1'b1, addr_t[i], 32'hA5A5A5A5, lat, err, rd, fa, fw);
      checks++; if (err !== 1'b1 || me !== 1'b1) begin fails++; $display("FAIL err_flag case=%0d got=%b exp=1", i, err); end
      checks++; if (rd !== 32'h0 || lat !== 1) begin fails++; $display("FAIL err_rsp case=%0d got rd=%h lat=%0d exp rd=0 lat=1", i, rd, lat); end
    end
    @(posedge clk); #1;
    checks++; if (bus_active !== act0) begin fails++; $display("FAIL err_bus_quiet got=%0d active cycles exp=0", bus_active - act0); end
  endtask

  task automatic test_random();
    int lat, ml;
    logic err, me, we, sgn;
    logic [1:0] sz;
    logic [31:0] rd, fa, mr, addr, wd;
    logic fw;
    for (int t = 0; t < 150; t++) begin
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 403));
      if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      ref_do(we, sz, sgn, addr, wd, me, mr, ml);
      do_req(we, sz, sgn, addr, wd, lat, err, rd, fa, fw);
      checks++; if (err !== me) begin fails++; $display("FAIL rnd_err t=%0d we=%b sz=%0d addr=%h got=%b exp=%b", t, we, sz, addr, err, me); end
      checks++; if (rd !== mr) begin fails++; $display("FAIL rnd_rdata t=%0d we=%b sz=%0d sgn=%b addr=%h got=%h exp=%h", t, we, sz, sgn, addr, rd, mr); end
      checks++; if (lat !== ml) begin fails++; $display("FAIL rnd_latency t=%0d we=%b sz=%0d addr=%h got=%0d exp=%0d", t, we, sz, addr, lat, ml); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int accepts, rsps, bad, ml, n;
    logic pre_ready, me;
    logic [31:0] exp;
    ref_do(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, me, exp, ml);
    n = 0;
    while (!io.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    accepts = 0; rsps = 0; bad = 0;
    io.req_we = 1'b0; io.req_size = SIZE_WORD; io.req_signed = 1'b0;
    io.req_addr = 32'h40; io.req_wdata = '0; io.req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pre_ready = io.req_ready;
      @(posedge clk); #1;
      if (pre_ready) accepts++;
      if (io.rsp_valid) begin
        rsps++;
        if (io.rsp_rdata !== exp || io.rsp_err !== 1'b0) bad++;
      end
    end
    io.req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (io.rsp_valid) rsps++;
    end
    checks++; if (accepts !== 4) begin fails++; $display("FAIL b2b_accepts got=%0d exp=4", accepts); end
    checks++; if (rsps !== 4) begin fails++; $display("FAIL b2b_responses got=%0d exp=4", rsps); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL b2b_rdata got=%0d bad responses exp=0 (exp data %h)", bad, exp); end
  endtask

  task automatic test_reset_mid();
    int r0, w0, ml, n;
    logic me;
    logic [31:0] mr, wd;
    n = 0;
    while (!io.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    r0 = rsp_seen; w0 = wr_seen;
    io.req_we = 1'b1; io.req_size = SIZE_BYTE; io.req_signed = 1'b0;
    io.req_addr = 32'h21; io.req_wdata = 32'h0000_0077; io.req_valid = 1'b1;
    @(posedge clk); #1;
    io.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (io.req_ready !== 1'b1 || io.rsp_valid !== 1'b0 || io.bus_addr !== 32'hFFFF_FFFF || io.bus_w_r !== 1'b0)
      begin fails++; $display("FAIL rst_rd_outputs got ready=%b rsp_valid=%b addr=%h w_r=%b exp 1 0 ffffffff 0", io.req_ready, io.rsp_valid, io.bus_addr, io.bus_w_r); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_seen !== r0 || wr_seen !== w0) begin fails++; $display("FAIL rst_rd_activity got rsp=%0d wr=%0d exp 0 0", rsp_seen - r0, wr_seen - w0); end
    checks++; if (mem[8] !== ref_word(8)) begin fails++; $display("FAIL rst_rd_mem got=%h exp=%h", mem[8], ref_word(8)); end

    wd = $urandom;
    ref_do(1'b1, SIZE_WORD, 1'b0, 32'h24, wd, me, mr, ml);
    r0 = rsp_seen;
    io.req_we = 1'b1; io.req_size = SIZE_WORD; io.req_addr = 32'h24; io.req_wdata = wd; io.req_valid = 1'b1;
    @(posedge clk); #1;
    io.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (io.req_ready !== 1'b1 || io.rsp_valid !== 1'b0 || io.rsp_err !== 1'b0 || io.rsp_rdata !== 32'h0 ||
                  io.bus_addr !== 32'hFFFF_FFFF || io.bus_w_r !== 1'b0 || io.bus_wdata !== 32'h0)
      begin fails++; $display("FAIL rst_wr_outputs got ready=%b rsp_valid=%b err=%b rdata=%h addr=%h w_r=%b wdata=%h exp reset values",
                              io.req_ready, io.rsp_valid, io.rsp_err, io.rsp_rdata, io.bus_addr, io.bus_w_r, io.bus_wdata); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_seen !== r0) begin fails++; $display("FAIL rst_wr_rsp got=%0d responses exp=0", rsp_seen - r0); end
    checks++; if (mem[9] !== wd) begin fails++; $display("FAIL rst_wr_mem got=%h exp=%h", mem[9], wd); end
  endtask

  task automatic test_final_mem();
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== ref_word(i)) bad++;
    checks++; if (bad !== 0) begin fails++; $display("FAIL final_mem got=%0d differing words exp=0", bad); end
  endtask

  initial begin
    io.req_valid = 1'b0; io.req_we = 1'b0; io.req_size = '0; io.req_signed = 1'b0;
    io.req_addr = '0; io.req_wdata = '0;
    rst = 1'b1;
    test_reset();
    test_directed();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_final_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule
